// File: rtl/ysyx_iqu.sv
// ============================================================================
//  Module   : ysyx_iqu
//  Brief    : ALU issue queue. Compacting, oldest-first select, CDB wakeup.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ysyx_iqu #(
    parameter int RS_SIZE = 4,
    parameter int TAG_W   = 5,
    parameter int XLEN    = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4:0]                 in_alu_op,
    input  logic [XLEN-1:0]            in_op1,
    input  logic [XLEN-1:0]            in_op2,
    input  logic [TAG_W-1:0]           in_qj,
    input  logic [TAG_W-1:0]           in_qk,
    input  logic [TAG_W-1:0]           in_dest,
    input  logic [31:0]                in_imm,
    input  logic [XLEN-1:0]            in_pc,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_dest,
    input  logic [XLEN-1:0]            cdb_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [4:0]                 out_alu_op,
    output logic [XLEN-1:0]            out_op1,
    output logic [XLEN-1:0]            out_op2,
    output logic [31:0]                out_imm,
    output logic [XLEN-1:0]            out_pc,
    output logic [TAG_W-1:0]           out_dest,
    output logic [$clog2(RS_SIZE):0]   count
);

    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int CNT_W = IDX_W + 1;

    logic [4:0]       r_alu_op [RS_SIZE];
    logic [XLEN-1:0]  r_op1    [RS_SIZE];
    logic [XLEN-1:0]  r_op2    [RS_SIZE];
    logic [31:0]      r_imm    [RS_SIZE];
    logic [XLEN-1:0]  r_pc     [RS_SIZE];
    logic [TAG_W-1:0] r_dest   [RS_SIZE];
    logic [TAG_W-1:0] r_qj     [RS_SIZE];
    logic [TAG_W-1:0] r_qk     [RS_SIZE];
    logic [CNT_W-1:0] r_count;

    logic [4:0]       w_alu_op [RS_SIZE];
    logic [XLEN-1:0]  w_op1    [RS_SIZE];
    logic [XLEN-1:0]  w_op2    [RS_SIZE];
    logic [31:0]      w_imm    [RS_SIZE];
    logic [XLEN-1:0]  w_pc     [RS_SIZE];
    logic [TAG_W-1:0] w_dest   [RS_SIZE];
    logic [TAG_W-1:0] w_qj     [RS_SIZE];
    logic [TAG_W-1:0] w_qk     [RS_SIZE];
    logic [CNT_W-1:0] w_count;

    logic             w_rdy    [RS_SIZE];
    logic             w_any;
    logic [IDX_W-1:0] w_sel;
    logic             w_deq;
    logic             w_enq;
    logic [CNT_W-1:0] w_wpos;
    logic [IDX_W-1:0] w_src;

    assign in_ready = (r_count < CNT_W'(RS_SIZE));
    assign count    = r_count;

    // Valid bits are implied by the compacted occupancy count.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            w_rdy[i] = (CNT_W'(i) < r_count) && (r_qj[i] == '0) && (r_qk[i] == '0);
        end
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (w_rdy[i]) begin
                w_any = 1'b1;
                w_sel = IDX_W'(i);
            end
        end
    end

    assign out_valid  = w_any;
    assign out_alu_op = r_alu_op[w_sel];
    assign out_op1    = r_op1[w_sel];
    assign out_op2    = r_op2[w_sel];
    assign out_imm    = r_imm[w_sel];
    assign out_pc     = r_pc[w_sel];
    assign out_dest   = r_dest[w_sel];

    assign w_deq   = w_any && out_ready;
    assign w_enq   = in_valid && in_ready;
    assign w_wpos  = r_count - CNT_W'(w_deq);
    assign w_count = r_count - CNT_W'(w_deq) + CNT_W'(w_enq);

    // Shift-down on issue, then wakeup, then the enqueue slot overrides.
    always_comb begin
        w_src = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            w_src = IDX_W'(i);
            if (w_deq && (i >= int'(w_sel)) && (i < RS_SIZE - 1)) begin
                w_src = IDX_W'(i + 1);
            end
            w_alu_op[i] = r_alu_op[w_src];
            w_op1[i]    = r_op1[w_src];
            w_op2[i]    = r_op2[w_src];
            w_imm[i]    = r_imm[w_src];
            w_pc[i]     = r_pc[w_src];
            w_dest[i]   = r_dest[w_src];
            w_qj[i]     = r_qj[w_src];
            w_qk[i]     = r_qk[w_src];
            if (cdb_valid && (w_qj[i] != '0) && (w_qj[i] == cdb_dest)) begin
                w_op1[i] = cdb_result;
                w_qj[i]  = '0;
            end
            if (cdb_valid && (w_qk[i] != '0) && (w_qk[i] == cdb_dest)) begin
                w_op2[i] = cdb_result;
                w_qk[i]  = '0;
            end
            if (w_enq && (w_wpos == CNT_W'(i))) begin
                w_alu_op[i] = in_alu_op;
                w_imm[i]    = in_imm;
                w_pc[i]     = in_pc;
                w_dest[i]   = in_dest;
                w_op1[i]    = in_op1;
                w_op2[i]    = in_op2;
                w_qj[i]     = in_qj;
                w_qk[i]     = in_qk;
                if (cdb_valid && (in_qj != '0) && (in_qj == cdb_dest)) begin
                    w_op1[i] = cdb_result;
                    w_qj[i]  = '0;
                end
                if (cdb_valid && (in_qk != '0) && (in_qk == cdb_dest)) begin
                    w_op2[i] = cdb_result;
                    w_qk[i]  = '0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else begin
            r_count <= w_count;
        end
    end

    // Payload needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clock) begin
        for (int i = 0; i < RS_SIZE; i++) begin
            r_alu_op[i] <= w_alu_op[i];
            r_op1[i]    <= w_op1[i];
            r_op2[i]    <= w_op2[i];
            r_imm[i]    <= w_imm[i];
            r_pc[i]     <= w_pc[i];
            r_dest[i]   <= w_dest[i];
            r_qj[i]     <= w_qj[i];
            r_qk[i]     <= w_qk[i];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_iqu.sv
// ============================================================================
//  Module   : tb_ysyx_iqu
//  Brief    : Directed self-checking bench for ysyx_iqu.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_iqu;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_alu_op;
    logic [31:0] in_op1, in_op2, in_imm, in_pc;
    logic [4:0]  in_qj, in_qk, in_dest;
    logic        cdb_valid;
    logic [4:0]  cdb_dest;
    logic [31:0] cdb_result;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_alu_op;
    logic [31:0] out_op1, out_op2, out_imm, out_pc;
    logic [4:0]  out_dest;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    ysyx_iqu #(.RS_SIZE(4), .TAG_W(5), .XLEN(32)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_alu_op(in_alu_op),
        .in_op1(in_op1), .in_op2(in_op2), .in_qj(in_qj), .in_qk(in_qk),
        .in_dest(in_dest), .in_imm(in_imm), .in_pc(in_pc),
        .cdb_valid(cdb_valid), .cdb_dest(cdb_dest), .cdb_result(cdb_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_alu_op(out_alu_op),
        .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm),
        .out_pc(out_pc), .out_dest(out_dest), .count(count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic enq(input logic [4:0] dest, input logic [4:0] qj, input logic [4:0] qk,
                       input logic [31:0] op1, input logic [31:0] op2);
        in_valid  = 1'b1;
        in_dest   = dest;
        in_qj     = qj;
        in_qk     = qk;
        in_op1    = op1;
        in_op2    = op2;
        in_alu_op = dest + 5'd10;
        in_imm    = 32'h100 + 32'(dest);
        in_pc     = 32'h8000_0000 + 32'(dest) * 4;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        cdb_valid = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_alu_op = '0; in_op1 = '0; in_op2 = '0; in_imm = '0; in_pc = '0;
        in_qj = '0; in_qk = '0; in_dest = '0;
        cdb_valid = 1'b0; cdb_dest = '0; cdb_result = '0;
        tick(); tick();
        reset = 1'b1;
        #1;
        chk("rst_count",    32'(count), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);

        // Ready op: visible the cycle after enqueue, drains with out_ready
        enq(5'd3, 5'd0, 5'd0, 32'd5, 32'd7);
        tick(); idle(); #1;
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_op1",   out_op1, 5);
        chk("t1_op2",   out_op2, 7);
        chk("t1_dest",  32'(out_dest), 3);
        chk("t1_aluop", 32'(out_alu_op), 13);
        chk("t1_imm",   out_imm, 32'h103);
        chk("t1_pc",    out_pc, 32'h8000_000C);
        chk("t1_count", 32'(count), 1);
        out_ready = 1'b1;
        tick(); #1;
        chk("t1_drain", 32'(count), 0);
        chk("t1_empty", 32'(out_valid), 0);

        // Wakeup of a stored entry
        enq(5'd1, 5'd4, 5'd0, 32'h0, 32'd9);
        tick(); idle(); #1;
        chk("t2_wait", 32'(out_valid), 0);
        chk("t2_count", 32'(count), 1);
        cdb_valid = 1'b1; cdb_dest = 5'd4; cdb_result = 32'hDEAD;
        #1;
        chk("t2_not_same_cycle", 32'(out_valid), 0);
        tick(); cdb_valid = 1'b0; #1;
        chk("t2_valid", 32'(out_valid), 1);
        chk("t2_op1",   out_op1, 32'hDEAD);
        chk("t2_op2",   out_op2, 9);
        chk("t2_dest",  32'(out_dest), 1);
        tick(); #1;
        chk("t2_drain", 32'(count), 0);

        // Enqueue bypass on both operands
        out_ready = 1'b0;
        enq(5'd2, 5'd6, 5'd6, 32'h55, 32'h66);
        cdb_valid = 1'b1; cdb_dest = 5'd6; cdb_result = 32'h10;
        tick(); idle(); #1;
        chk("t3_valid", 32'(out_valid), 1);
        chk("t3_op1",   out_op1, 32'h10);
        chk("t3_op2",   out_op2, 32'h10);
        out_ready = 1'b1;
        tick(); #1;
        chk("t3_drain", 32'(count), 0);

        // Fill: dest1 waits on tag 9, dests 2..4 ready
        out_ready = 1'b0;
        enq(5'd1, 5'd9, 5'd0, 32'h0, 32'h0);    tick();
        enq(5'd2, 5'd0, 5'd0, 32'h22, 32'h0);   tick();
        enq(5'd3, 5'd0, 5'd0, 32'h23, 32'h0);   tick();
        enq(5'd4, 5'd0, 5'd0, 32'h24, 32'h0);   tick();
        idle(); #1;
        chk("t4_count", 32'(count), 4);
        chk("t4_in_ready", 32'(in_ready), 0);
        chk("t4_sel", 32'(out_dest), 2);

        // Full + issue + in_valid: new op rejected, count 4 -> 3
        enq(5'd7, 5'd0, 5'd0, 32'h77, 32'h0);
        out_ready = 1'b1;
        #1;
        chk("t5_full_ready", 32'(in_ready), 0);
        tick(); idle(); #1;
        chk("t5_count", 32'(count), 3);
        chk("t5_in_ready", 32'(in_ready), 1);
        chk("t5_sel", 32'(out_dest), 3);
        chk("t5_op1", out_op1, 32'h23);
        tick(); #1;
        chk("t4_sel4", 32'(out_dest), 4);
        chk("t4_count2", 32'(count), 2);
        tick(); #1;
        chk("t4_count1", 32'(count), 1);
        chk("t4_blocked", 32'(out_valid), 0);
        cdb_valid = 1'b1; cdb_dest = 5'd9; cdb_result = 32'h99;
        tick(); cdb_valid = 1'b0; #1;
        chk("t4_last_valid", 32'(out_valid), 1);
        chk("t4_last_dest", 32'(out_dest), 1);
        chk("t4_last_op1", out_op1, 32'h99);
        tick(); #1;
        chk("t4_rejected_absent", 32'(count), 0);

        // Simultaneous enqueue + issue keeps count
        out_ready = 1'b0;
        enq(5'd1, 5'd0, 5'd0, 32'h1, 32'h0);    tick();
        enq(5'd2, 5'd0, 5'd0, 32'h2, 32'h0);
        out_ready = 1'b1;
        tick(); idle(); #1;
        chk("t7_count", 32'(count), 1);
        chk("t7_dest", 32'(out_dest), 2);
        tick(); #1;
        chk("t7_drain", 32'(count), 0);

        // Flush with in_valid
        out_ready = 1'b0;
        enq(5'd1, 5'd0, 5'd0, 32'h1, 32'h0);    tick();
        enq(5'd2, 5'd0, 5'd0, 32'h2, 32'h0);    tick();
        enq(5'd3, 5'd0, 5'd0, 32'h3, 32'h0);    tick();
        idle(); #1;
        chk("t6_pre", 32'(count), 3);
        enq(5'd5, 5'd0, 5'd0, 32'h5, 32'h0);
        flush = 1'b1;
        tick(); idle(); #1;
        chk("t6_count", 32'(count), 0);
        chk("t6_valid", 32'(out_valid), 0);
        enq(5'd6, 5'd0, 5'd0, 32'h6, 32'h0);    tick();
        idle(); #1;
        chk("t6_after_count", 32'(count), 1);
        chk("t6_after_dest", 32'(out_dest), 6);

        // Reset mid-operation
        enq(5'd8, 5'd0, 5'd0, 32'h8, 32'h0);    tick();
        idle(); #1;
        chk("t8_pre", 32'(count), 2);
        reset = 1'b0;
        tick(); reset = 1'b1; #1;
        chk("t8_count", 32'(count), 0);
        chk("t8_in_ready", 32'(in_ready), 1);
        chk("t8_valid", 32'(out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/ysyx_iqu.md
Name: ysyx_iqu

Overview:
- Issue queue / reservation station between decode (IDU) and the ALU execute stage (EXU).
- Buffers decoded micro-ops whose source operands may still be pending on ROB tags, and snoops the common data bus (CDB) to capture results.
- Issues the oldest entry with both operands ready to the EXU over a valid/ready handshake.

Parameters:
- RS_SIZE, 4, number of queue entries (power of two ≥2).
- TAG_W, 5, ROB tag width (clog2(YSYX_ROB_SIZE)+1). Tag value 0 means "operand ready".
- XLEN, 32, data width (YSYX_XLEN).

Ports:
- clock  in  1  clock
- reset  in  1  synchronous reset, active-low
- flush  in  1  pipeline flush (mispredict/trap); clears all entries
- in_valid  in  1  IDU presents a micro-op
- in_ready  out  1  queue can accept
- in_alu_op  in  5  ALU opcode
- in_op1, in_op2  in  XLEN  operand values (meaningful only when matching tag is 0)
- in_qj, in_qk  in  TAG_W  producer tags for op1/op2; 0 = ready
- in_dest  in  TAG_W  ROB tag of this micro-op
- in_imm  in  32  immediate
- in_pc  in  XLEN  instruction PC
- cdb_valid  in  1  CDB broadcast valid
- cdb_dest  in  TAG_W  tag being broadcast (never 0)
- cdb_result  in  XLEN  broadcast value
- out_valid  out  1  ready micro-op available to EXU
- out_ready  in  1  EXU accepts
- out_alu_op, out_op1, out_op2, out_imm, out_pc, out_dest  out  as inputs  issued payload
- count  out  clog2(RS_SIZE)+1  occupied entries

Behaviour:
- Storage is a compacting queue. Entry 0 is the oldest. Per entry: valid, payload, qj, qk.
- Reset (reset==0 at posedge): all entry valid bits cleared, count=0. Payload contents are don't-care.
  - Outputs after reset: in_ready=1, out_valid=0.
  - Reset mid-operation discards everything. Reset has priority over flush, enqueue and issue.
- in_ready = (count < RS_SIZE).
  - This is conservative: a simultaneous issue does not free a slot for an enqueue in the same cycle.
- Enqueue: when in_valid && in_ready, the micro-op is written at position (count − issued_this_cycle), i.e. behind all surviving entries.
- Same-cycle wakeup bypass at enqueue:
  - If cdb_valid && in_qj==cdb_dest && in_qj!=0, store op1=cdb_result and qj=0.
  - Same rule for qk/op2.
- Wakeup of stored entries: each cycle, for every valid entry with qj==cdb_dest (nonzero) and cdb_valid, set op1=cdb_result and qj=0. Same for qk/op2. Both operands may wake in the same cycle.
- Ready(i) = valid(i) && qj(i)==0 && qk(i)==0, evaluated on registered state.
  - An operand woken in cycle t makes its entry issuable in cycle t+1 at the earliest.
- Issue (combinational select):
  - out_valid = OR of Ready(i).
  - Selected entry is the lowest index with Ready. Out_* is driven from that entry.
  - Out_* is don't-care when out_valid=0.
- Dequeue: on out_valid && out_ready, the selected entry is removed. Entries above it shift down by one, preserving order; CDB wakeup applies to shifted entries in the same cycle.
- Minimum latency: micro-op enqueued ready at edge t is visible on out_valid in the cycle after edge t.
- Simultaneous enqueue + issue: both occur; count is unchanged.
- Full + issue: issue proceeds; in_ready stays 0 that cycle and returns to 1 next cycle.
- Flush (flush==1 at posedge, reset inactive): all valid bits cleared, count=0.
  - An enqueue in the same cycle is dropped.
  - out_valid may be 1 during the flush cycle. The EXU is responsible for discarding it (flush is also routed to the EXU).
- A tag matching no entry is ignored. Broadcast with cdb_valid=0 has no effect.
- No assertions of in_* are required when in_valid=0.

Test Plan:
- Reset then enqueue {qj=0,qk=0,op1=5,op2=7,dest=3} -> cycle after: out_valid=1, out_op1=5, out_op2=7, out_dest=3; with out_ready=1, count returns to 0.
- Enqueue dest=1 with qj=4, qk=0; out_valid stays 0; broadcast cdb_dest=4, result=0xDEAD -> next cycle out_valid=1, out_op1=0xDEAD.
- Enqueue qj=6 in the same cycle as cdb_valid, cdb_dest=6, result=0x10 (bypass) -> next cycle out_valid=1, out_op1=0x10.
- Fill 4 entries (dests 1..4; dest 1 waits on tag 9, others ready), out_ready=0 -> in_ready=0, count=4. Then out_ready=1 -> issues dest 2,3,4 in order. Broadcast tag 9 -> dest 1 issues last.
- Full queue with issue and in_valid both asserted in one cycle -> new op not accepted, count goes 4→3, in_ready=1 next cycle.
- 3 entries held, assert flush with in_valid=1 -> next cycle count=0, out_valid=0, flush-cycle op absent. Reset asserted with 2 entries -> count=0, in_ready=1.
